// File: rtl/core_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 width codes and FSM/size enums.
package core_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } lsu_size_t;

endpackage

// File: rtl/core_lsu_if.sv
// Request/response handshake from the execute stage plus the data SRAM port of the LSU.
interface core_lsu_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic              req_ld;
  logic              req_st;
  logic [2:0]        req_funct3;
  logic [XLEN-1:0]   req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic [4:0]        req_rd_a;

  logic              resp_valid;
  logic [4:0]        resp_rd_a;
  logic [XLEN-1:0]   resp_rdata;
  logic              resp_err;

  logic [ADDR_W-1:0] dat_a;
  logic [3:0]        dat_we;
  logic [XLEN-1:0]   dat_wd;
  logic [3:0]        dat_re;
  logic [XLEN-1:0]   dat_rd;

  modport slave (
    input  req_valid, req_ld, req_st, req_funct3, req_addr, req_wdata, req_rd_a, dat_rd,
    output req_ready, resp_valid, resp_rd_a, resp_rdata, resp_err,
    output dat_a, dat_we, dat_wd, dat_re
  );

  modport master (
    output req_valid, req_ld, req_st, req_funct3, req_addr, req_wdata, req_rd_a, dat_rd,
    input  req_ready, resp_valid, resp_rd_a, resp_rdata, resp_err,
    input  dat_a, dat_we, dat_wd, dat_re
  );
endinterface

// File: rtl/core_lsu_align.sv
// Combinational byte-lane logic: lane mask, store replication, load extract/extend, misalign flag.
module core_lsu_align
  import core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            is_ld,
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata,
  output logic [3:0]      lanes,
  output logic [XLEN-1:0] wd,
  output logic [XLEN-1:0] ld_data,
  output logic            misalign
);

  lsu_size_t       size;
  logic [1:0]      off;
  logic [XLEN-1:0] shifted;

  function automatic logic [XLEN-1:0] ext8(input logic [7:0] b, input logic uns);
    logic signed [7:0]      sb;
    logic signed [XLEN-1:0] s;
    sb = signed'(b);
    s  = sb;
    return uns ? {{(XLEN-8){1'b0}}, b} : s;
  endfunction

  function automatic logic [XLEN-1:0] ext16(input logic [15:0] h, input logic uns);
    logic signed [15:0]     sh;
    logic signed [XLEN-1:0] s;
    sh = signed'(h);
    s  = sh;
    return uns ? {{(XLEN-16){1'b0}}, h} : s;
  endfunction

  // Undefined codes fall back to word; misaligned offsets are forced onto the natural boundary.
  always_comb begin
    size = SZ_W;
    if (is_ld) begin
      case (funct3)
        F3_B, F3_BU: size = SZ_B;
        F3_H, F3_HU: size = SZ_H;
        default:     size = SZ_W;
      endcase
    end else begin
      case (funct3)
        F3_B:    size = SZ_B;
        F3_H:    size = SZ_H;
        default: size = SZ_W;
      endcase
    end
    case (size)
      SZ_B:    off = addr_lo;
      SZ_H:    off = {addr_lo[1], 1'b0};
      default: off = 2'b00;
    endcase
  end

  assign misalign = ((size == SZ_H) && addr_lo[0]) ||
                    ((size == SZ_W) && (addr_lo != 2'b00));

  assign shifted = rdata >> {off, 3'b000};

  always_comb begin
    lanes   = 4'hF;
    wd      = wdata;
    ld_data = shifted;
    case (size)
      SZ_B: begin
        lanes   = 4'b0001 << off;
        wd      = {4{wdata[7:0]}};
        ld_data = ext8(shifted[7:0], funct3[2]);
      end
      SZ_H: begin
        lanes   = 4'b0011 << off;
        wd      = {2{wdata[15:0]}};
        ld_data = ext16(shifted[15:0], funct3[2]);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/core_lsu.sv
// RV32 load/store unit: one request per handshake, registered SRAM port, RD_LAT-cycle load wait.
// Build option CORE_LSU_MISALIGN_EN: misaligned half/word accesses fault instead of being aligned.
module core_lsu
  import core_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic      clk,
  input  logic      rstn,
  core_lsu_if.slave bus
);

  lsu_state_t      state, state_nxt;
  logic [1:0]      cnt_p0;
  logic            ld_p0, ldgo_p0, err_p0;
  logic [2:0]      f3_p0;
  logic [1:0]      off_p0;
  logic [4:0]      rd_p0;

  logic            req_fire, req_is_st, req_err, go_ld, go_st;
  logic            al_is_ld;
  logic [2:0]      al_f3;
  logic [1:0]      al_off;
  logic [3:0]      lanes;
  logic [XLEN-1:0] wd, ld_data;
  logic            misalign;

  logic            unused_addr;
  assign unused_addr = ^bus.req_addr[XLEN-1:ADDR_W+2];

  assign req_fire  = (state == IDLE) && bus.req_valid;
  assign req_is_st = bus.req_st && !bus.req_ld;

  // The aligner sees the live request while idle and the captured request afterwards.
  assign al_is_ld = (state == IDLE) ? bus.req_ld         : ld_p0;
  assign al_f3    = (state == IDLE) ? bus.req_funct3     : f3_p0;
  assign al_off   = (state == IDLE) ? bus.req_addr[1:0]  : off_p0;

  core_lsu_align #(.XLEN(XLEN)) u_align (
    .is_ld    (al_is_ld),
    .funct3   (al_f3),
    .addr_lo  (al_off),
    .wdata    (bus.req_wdata),
    .rdata    (bus.dat_rd),
    .lanes    (lanes),
    .wd       (wd),
    .ld_data  (ld_data),
    .misalign (misalign)
  );

`ifdef CORE_LSU_MISALIGN_EN
  assign req_err = (bus.req_ld || bus.req_st) && misalign;
`else
  logic unused_misalign;
  assign unused_misalign = misalign;
  assign req_err         = 1'b0;
`endif

  assign go_ld = bus.req_ld && !req_err;
  assign go_st = req_is_st && !req_err;

  // Stage p0: request capture
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ld_p0   <= 1'b0;
      ldgo_p0 <= 1'b0;
      err_p0  <= 1'b0;
    end else if (req_fire) begin
      ld_p0   <= bus.req_ld;
      ldgo_p0 <= go_ld;
      err_p0  <= req_err;
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) begin
      f3_p0  <= bus.req_funct3;
      off_p0 <= bus.req_addr[1:0];
      rd_p0  <= bus.req_rd_a;
    end
  end

  // SRAM port registers are live only during ACC and return to zero on the next edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.dat_a  <= '0;
      bus.dat_we <= '0;
      bus.dat_wd <= '0;
      bus.dat_re <= '0;
    end else begin
      bus.dat_a  <= '0;
      bus.dat_we <= '0;
      bus.dat_wd <= '0;
      bus.dat_re <= '0;
      if (req_fire && (go_ld || go_st)) begin
        bus.dat_a <= bus.req_addr[ADDR_W+1:2];
        if (go_st) begin
          bus.dat_we <= lanes;
          bus.dat_wd <= wd;
        end else begin
          bus.dat_re <= lanes;
        end
      end
    end
  end

  // cnt_p0 holds the WAIT cycles still owed; RESP follows the cycle in which it reads 1.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)               cnt_p0 <= 2'd0;
    else if (state == ACC)   cnt_p0 <= 2'(RD_LAT - 1);
    else if (state == WAIT)  cnt_p0 <= cnt_p0 - 2'd1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.req_valid) state_nxt = ACC;
      ACC: begin
        if (!ldgo_p0)         state_nxt = IDLE;
        else if (RD_LAT == 1) state_nxt = RESP;
        else                  state_nxt = WAIT;
      end
      WAIT:    if (cnt_p0 == 2'd1) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = (state == IDLE);
    bus.resp_valid = 1'b0;
    bus.resp_rd_a  = '0;
    bus.resp_rdata = '0;
    bus.resp_err   = 1'b0;
    case (state)
      ACC: begin
        if (!ldgo_p0) begin
          bus.resp_valid = 1'b1;
          bus.resp_err   = err_p0;
        end
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_rd_a  = rd_p0;
        bus.resp_rdata = ld_data;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_core_lsu.sv
// Directed bench for core_lsu with RD_LAT=3: vector table plus back-to-back and reset sequences.
module tb_core_lsu;
  import core_pkg::*;

  localparam int RD_LAT = 3;
  localparam int LD_LAT = 1 + RD_LAT;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  core_lsu_if #(.XLEN(32), .ADDR_W(16)) bus ();

  core_lsu #(.XLEN(32), .ADDR_W(16), .RD_LAT(RD_LAT)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // SRAM stand-in: read data is only meaningful exactly RD_LAT cycles after dat_re.
  logic [31:0] rd_val = 32'h0;
  logic [3:0]  re_sh  = 4'h0;
  always @(posedge clk) re_sh <= {re_sh[2:0], |bus.dat_re};
  assign bus.dat_rd = re_sh[RD_LAT-1] ? rd_val : 32'hDEAD_0000;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] rdval;
    logic [15:0] e_a;
    logic [3:0]  e_we;
    logic [31:0] e_wd;
    logic [3:0]  e_re;
    int          lat;
    logic [31:0] e_rdata;
    logic [4:0]  e_rd;
    logic        e_err;
  } vec_t;

  vec_t vecs [14];

  task automatic drive_req(input logic ld, input logic st, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd);
    bus.req_valid  = 1'b1;
    bus.req_ld     = ld;
    bus.req_st     = st;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.req_rd_a   = rd;
  endtask

  task automatic run_vec(input int i, input vec_t v);
    @(negedge clk);
    drive_req(v.ld, v.st, v.f3, v.addr, v.wdata, v.rd);
    rd_val = v.rdval;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk($sformatf("v%0d req_ready", i), 32'(bus.req_ready), 32'd0);
    chk($sformatf("v%0d dat_a", i),  32'(bus.dat_a),  32'(v.e_a));
    chk($sformatf("v%0d dat_we", i), 32'(bus.dat_we), 32'(v.e_we));
    chk($sformatf("v%0d dat_wd", i), bus.dat_wd, v.e_wd);
    chk($sformatf("v%0d dat_re", i), 32'(bus.dat_re), 32'(v.e_re));
    for (int c = 1; c <= v.lat; c++) begin
      if (c > 1) begin
        @(negedge clk);
        chk($sformatf("v%0d sram idle c%0d", i, c), 32'({bus.dat_re, bus.dat_we}), 32'd0);
      end
      if (c < v.lat) begin
        chk($sformatf("v%0d resp early c%0d", i, c), 32'(bus.resp_valid), 32'd0);
      end else begin
        chk($sformatf("v%0d resp_valid", i), 32'(bus.resp_valid), 32'd1);
        chk($sformatf("v%0d resp_rdata", i), bus.resp_rdata, v.e_rdata);
        chk($sformatf("v%0d resp_rd_a", i),  32'(bus.resp_rd_a), 32'(v.e_rd));
        chk($sformatf("v%0d resp_err", i),   32'(bus.resp_err), 32'(v.e_err));
      end
    end
    @(negedge clk);
    chk($sformatf("v%0d ready after", i), 32'(bus.req_ready), 32'd1);
    chk($sformatf("v%0d resp single", i), 32'(bus.resp_valid), 32'd0);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b1, F3_W,   32'h104, 32'hDEADBEEF, 5'd7,  32'h0,
                 16'h41, 4'hF,    32'hDEADBEEF, 4'h0,    1,      32'h0,        5'd0,  1'b0};
    vecs[1]  = '{1'b0, 1'b1, F3_B,   32'h13,  32'h000000A5, 5'd1,  32'h0,
                 16'h4,  4'b1000, 32'hA5A5A5A5, 4'h0,    1,      32'h0,        5'd0,  1'b0};
    vecs[2]  = '{1'b1, 1'b0, F3_B,   32'h22,  32'h0,        5'd5,  32'h00800000,
                 16'h8,  4'h0,    32'h0,        4'b0100, LD_LAT, 32'hFFFFFF80, 5'd5,  1'b0};
    vecs[3]  = '{1'b1, 1'b0, F3_BU,  32'h22,  32'h0,        5'd5,  32'h00800000,
                 16'h8,  4'h0,    32'h0,        4'b0100, LD_LAT, 32'h00000080, 5'd5,  1'b0};
    vecs[4]  = '{1'b0, 1'b1, F3_H,   32'h6,   32'h1234BEEF, 5'd2,  32'h0,
                 16'h1,  4'b1100, 32'hBEEFBEEF, 4'h0,    1,      32'h0,        5'd0,  1'b0};
    vecs[5]  = '{1'b1, 1'b0, F3_H,   32'h2,   32'h0,        5'd10, 32'h80010000,
                 16'h0,  4'h0,    32'h0,        4'b1100, LD_LAT, 32'hFFFF8001, 5'd10, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, F3_HU,  32'h0,   32'h0,        5'd11, 32'h1234F00F,
                 16'h0,  4'h0,    32'h0,        4'b0011, LD_LAT, 32'h0000F00F, 5'd11, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, F3_W,   32'h40,  32'h0,        5'd31, 32'hCAFEBABE,
                 16'h10, 4'h0,    32'h0,        4'hF,    LD_LAT, 32'hCAFEBABE, 5'd31, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, F3_B,   32'h1,   32'hFFFFFFFF, 5'd12, 32'h0000FE00,
                 16'h0,  4'h0,    32'h0,        4'b0010, LD_LAT, 32'hFFFFFFFE, 5'd12, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, F3_W,   32'h100, 32'h00000055, 5'd13, 32'h0,
                 16'h0,  4'h0,    32'h0,        4'h0,    1,      32'h0,        5'd0,  1'b0};
    vecs[10] = '{1'b0, 1'b1, 3'b100, 32'h8,   32'h11223344, 5'd14, 32'h0,
                 16'h2,  4'hF,    32'h11223344, 4'h0,    1,      32'h0,        5'd0,  1'b0};
    vecs[11] = '{1'b1, 1'b0, 3'b011, 32'hC,   32'h0,        5'd15, 32'h55667788,
                 16'h3,  4'h0,    32'h0,        4'hF,    LD_LAT, 32'h55667788, 5'd15, 1'b0};
`ifdef CORE_LSU_MISALIGN_EN
    vecs[12] = '{1'b1, 1'b0, F3_H,   32'h1,   32'h0,        5'd3,  32'hABCD1234,
                 16'h0,  4'h0,    32'h0,        4'h0,    1,      32'h0,        5'd0,  1'b1};
    vecs[13] = '{1'b0, 1'b1, F3_W,   32'h6,   32'h01020304, 5'd4,  32'h0,
                 16'h0,  4'h0,    32'h0,        4'h0,    1,      32'h0,        5'd0,  1'b1};
`else
    vecs[12] = '{1'b1, 1'b0, F3_H,   32'h1,   32'h0,        5'd3,  32'hABCD1234,
                 16'h0,  4'h0,    32'h0,        4'b0011, LD_LAT, 32'h00001234, 5'd3,  1'b0};
    vecs[13] = '{1'b0, 1'b1, F3_W,   32'h6,   32'h01020304, 5'd4,  32'h0,
                 16'h1,  4'hF,    32'h01020304, 4'h0,    1,      32'h0,        5'd0,  1'b0};
`endif

    bus.req_valid  = 1'b0;
    bus.req_ld     = 1'b0;
    bus.req_st     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.req_rd_a   = 5'd0;

    repeat (2) @(negedge clk);
    chk("rst req_ready",  32'(bus.req_ready),  32'd1);
    chk("rst resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst resp_rd_a",  32'(bus.resp_rd_a),  32'd0);
    chk("rst resp_rdata", bus.resp_rdata,      32'd0);
    chk("rst resp_err",   32'(bus.resp_err),   32'd0);
    chk("rst dat_a",      32'(bus.dat_a),      32'd0);
    chk("rst dat_we",     32'(bus.dat_we),     32'd0);
    chk("rst dat_wd",     bus.dat_wd,          32'd0);
    chk("rst dat_re",     32'(bus.dat_re),     32'd0);
    rstn = 1'b1;

    for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

    // Load with a second request held valid: next accept comes one edge after the response.
    @(negedge clk);
    drive_req(1'b1, 1'b0, F3_W, 32'h40, 32'h0, 5'd9);
    rd_val = 32'h0BADCAFE;
    @(posedge clk);
    @(negedge clk);
    drive_req(1'b0, 1'b1, F3_W, 32'h104, 32'h13572468, 5'd1);
    for (int c = 1; c <= LD_LAT; c++) begin
      if (c > 1) @(negedge clk);
      chk($sformatf("b2b ready low c%0d", c), 32'(bus.req_ready), 32'd0);
      chk($sformatf("b2b resp c%0d", c), 32'(bus.resp_valid), (c == LD_LAT) ? 32'd1 : 32'd0);
    end
    chk("b2b rdata", bus.resp_rdata, 32'h0BADCAFE);
    chk("b2b rd_a",  32'(bus.resp_rd_a), 32'd9);
    @(negedge clk);
    chk("b2b ready idle", 32'(bus.req_ready), 32'd1);
    chk("b2b no early we", 32'(bus.dat_we), 32'd0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("b2b st we",   32'(bus.dat_we), 32'hF);
    chk("b2b st a",    32'(bus.dat_a),  32'h41);
    chk("b2b st wd",   bus.dat_wd,      32'h13572468);
    chk("b2b st resp", 32'(bus.resp_valid), 32'd1);
    @(negedge clk);
    chk("b2b end ready", 32'(bus.req_ready), 32'd1);

    // Store throughput: two stores held valid complete two cycles apart.
    @(negedge clk);
    drive_req(1'b0, 1'b1, F3_W, 32'h20, 32'h0A0B0C0D, 5'd0);
    @(posedge clk);
    @(negedge clk);
    chk("st2 first resp", 32'(bus.resp_valid), 32'd1);
    chk("st2 first wd",   bus.dat_wd, 32'h0A0B0C0D);
    drive_req(1'b0, 1'b1, F3_W, 32'h24, 32'h11111111, 5'd0);
    @(negedge clk);
    chk("st2 gap ready", 32'(bus.req_ready), 32'd1);
    chk("st2 gap resp",  32'(bus.resp_valid), 32'd0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("st2 second resp", 32'(bus.resp_valid), 32'd1);
    chk("st2 second a",    32'(bus.dat_a), 32'h9);
    chk("st2 second wd",   bus.dat_wd, 32'h11111111);

    // Reset during WAIT of a load: pending load is dropped, request during reset ignored.
    @(negedge clk);
    drive_req(1'b1, 1'b0, F3_W, 32'h80, 32'h0, 5'd6);
    rd_val = 32'h76543210;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("rstw acc re", 32'(bus.dat_re), 32'hF);
    @(negedge clk);
    rstn = 1'b0;
    drive_req(1'b0, 1'b1, F3_W, 32'h84, 32'hFFFFFFFF, 5'd0);
    #1;
    chk("rstw ready",  32'(bus.req_ready),  32'd1);
    chk("rstw resp",   32'(bus.resp_valid), 32'd0);
    chk("rstw rdata",  bus.resp_rdata,      32'd0);
    chk("rstw sram",   32'({bus.dat_re, bus.dat_we, bus.dat_a}), 32'd0);
    @(negedge clk);
    chk("rstw ignore", 32'({bus.dat_we, bus.dat_wd[15:0]}), 32'd0);
    bus.req_valid = 1'b0;
    rstn = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("rstw no resp c%0d", c), 32'(bus.resp_valid), 32'd0);
    end
    chk("rstw final ready", 32'(bus.req_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_lsu.md
# core_lsu

Parametrised load/store unit for the RISC-V core: accepts one load or store per handshake from the execute stage and drives the data SRAM port. It generates byte-lane enables and replicated write data, waits a configurable SRAM read latency, and returns sign- or zero-extended load data with the destination register index. It fills the LSU slot between the execute stage and the data SRAM. It replaces the fixed single-cycle data access of the first-generation core.

## Interface
- XLEN, 32: data path width. Only 32 is supported.
- ADDR_W, 16: SRAM word-address width. `dat_a` = `req_addr[ADDR_W+1:2]`.
- RD_LAT, 1: number of cycles from the SRAM seeing `dat_re` to `dat_rd` being valid. Legal range 1..4.

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_ld  in  1  request is a load
- req_st  in  1  request is a store
- req_funct3  in  3  RV32I width/sign code
- req_addr  in  XLEN  byte address
- req_wdata  in  XLEN  store data, taken from the low bytes
- req_rd_a  in  5  load destination register
- resp_valid  out  1  one-cycle completion pulse
- resp_rd_a  out  5  destination register; 0 for stores and no-ops
- resp_rdata  out  XLEN  extended load data; 0 otherwise
- resp_err  out  1  misaligned access
- dat_a  out  ADDR_W  SRAM word address
- dat_we  out  4  byte write enables
- dat_wd  out  XLEN  write data
- dat_re  out  4  byte read enables
- dat_rd  in  XLEN  read data

## Operation
- FSM states: IDLE, ACC, WAIT, RESP. `req_ready` = (state==IDLE).
- **IDLE:** on `req_valid`, latch the request and go to ACC. If both `req_ld` and `req_st` are set, the request is a load. If neither is set, it is a no-op.
- **ACC:** drive the registered SRAM outputs for exactly one cycle.
  - Store or no-op: pulse `resp_valid` in this same cycle and return to IDLE.
  - Load: assert `dat_re`, load the latency counter with RD_LAT-1, and go to WAIT. If RD_LAT==1, go directly to RESP.
- **WAIT:** decrement the counter; at 0 go to RESP. `dat_re`, `dat_we` and `dat_a` are all 0 in this state.
- **RESP:** sample `dat_rd`, extract and extend it, pulse `resp_valid`, return to IDLE.
- Lane mask from funct3[1:0] and `addr[1:0]`:
  - byte: `4'b0001 << addr[1:0]`
  - half: `4'b0011 << {addr[1],1'b0}`
  - word: `4'hF`
- Store data is replicated: SB writes `{4{b}}`, SH writes `{2{h}}`, SW writes the word.
- Load data is shifted right by `addr[1:0]*8`. LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
- Undefined funct3 codes (load 011/110/111, store ≥011) are treated as word accesses.
- Reset, including mid-operation: state goes to IDLE and every output register clears. Any pending load is discarded with no response. `req_valid` is ignored while rstn is low.

## Timing
- Request accepted at edge T.
- Store: SRAM access and `resp_valid` both occur in cycle T+1.
- Load: `dat_re` is asserted in cycle T+1; `resp_valid` arrives in cycle T+1+RD_LAT.
- Throughput:
  - store: one per 2 cycles
  - load: one per 2+RD_LAT cycles
- Reset values:
  - `req_ready`=1
  - `resp_valid`, `resp_rd_a`, `resp_rdata`, `resp_err`=0
  - `dat_a`, `dat_we`, `dat_wd`, `dat_re`=0
- `dat_we` and `dat_re` are never both non-zero in the same cycle.

## Configuration
- Macro: `CORE_LSU_MISALIGN_EN`.
- **Defined:** a halfword access with `addr[0]`=1, or a word access with `addr[1:0]`≠0, performs no SRAM access (we/re stay 0). `resp_valid` pulses at T+1 with `resp_err`=1, `resp_rdata`=0 and `resp_rd_a`=0.
- **Undefined:** misaligned low address bits are cleared for the lane and shift computation. The access proceeds aligned and `resp_err` is tied to 0.

## Structure
- Package `core_pkg` holds:
  - funct3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU
  - the `lsu_state_t` enum
- Combinational sub-module `core_lsu_align` produces the lane mask, the replicated write data, the load extract/extend and the misalign flag. The FSM, counter and registers stay in `core_lsu`.

## Test plan
- SW to addr 0x0000_0104 with data 0xDEADBEEF → T+1: `dat_a`=0x41, `dat_we`=4'hF, `dat_wd`=0xDEADBEEF, `resp_valid`=1, `resp_rd_a`=0.
- SB to addr 0x0000_0013 with data 0x000000A5 → `dat_we`=4'b1000, `dat_wd`=0xA5A5A5A5.
- With RD_LAT=3: LB from addr 0x0000_0022, rd=5, `dat_rd`=0x0080_0000 → `resp_valid` at T+4, `resp_rdata`=0xFFFF_FF80, `resp_rd_a`=5. LBU from the same address → `resp_rdata`=0x0000_0080.
- LH from addr 0x0000_0001 → with the macro: T+1 `resp_err`=1 and `dat_re`=0. Without it: `dat_re`=4'b0011 and `resp_err`=0.
- Back-to-back requests:
  - `req_ready` is low from T through the response cycle.
  - A second request held valid is accepted on the edge after `resp_valid`.
- rstn asserted during WAIT of an LW → all outputs return to 0 and `req_ready`=1. No `resp_valid` is emitted after rstn deasserts.
